// File: rtl/bist_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bist_pkg
//  Description : Shared types and default sizes for the BIST controller.
//                Holds the session state encoding, the signature and
//                pattern-counter widths, and the default pattern count
//                (2^4-1, the maximal period of the 4-bit LFSR TPG).
//  Revision    : 1.0 - initial release
// ============================================================================
package bist_pkg;

    localparam int SIG_W_DEF         = 4;
    localparam int CNT_W_DEF         = 4;
    localparam int PATTERN_COUNT_DEF = (1 << CNT_W_DEF) - 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INIT    = 3'd1,
        ST_RUN     = 3'd2,
        ST_FLUSH   = 3'd3,
        ST_COMPARE = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

endpackage : bist_pkg
`default_nettype wire

// File: rtl/bist_if.sv
`default_nettype none
// ============================================================================
//  Module      : bist_if
//  Description : Control/status bundle between the BIST controller and the
//                surrounding TPG/CUT/ORA top level.
//                slave  : controller side (start/abort/golden/signature in,
//                         tm/bist_init/status/result out)
//                master : top-level / requester side (mirror image)
//  Revision    : 1.0 - initial release
// ============================================================================
interface bist_if #(
    parameter int SIG_W = bist_pkg::SIG_W_DEF,
    parameter int CNT_W = bist_pkg::CNT_W_DEF
);
    logic             start;
    logic             abort;
    logic [SIG_W-1:0] golden;
    logic [SIG_W-1:0] signature;
    logic             tm;
    logic             bist_init;
    logic             busy;
    logic             done;
    logic             pass;
    logic             fail;
    logic [SIG_W-1:0] sig_latched;
    logic [CNT_W-1:0] pattern_idx;

    modport slave (
        input  start, abort, golden, signature,
        output tm, bist_init, busy, done, pass, fail, sig_latched, pattern_idx
    );

    modport master (
        output start, abort, golden, signature,
        input  tm, bist_init, busy, done, pass, fail, sig_latched, pattern_idx
    );
endinterface : bist_if
`default_nettype wire

// File: rtl/bist_controller.sv
`default_nettype none
// ============================================================================
//  Module      : bist_controller
//  Description : Sequences one BIST session: INIT (re-initialise TPG/ORA),
//                RUN (PATTERN_COUNT patterns with tm=1), FLUSH (ORA captures
//                the last response), COMPARE (latch signature, compare with
//                golden), DONE (hold result until the next start).
//  Ports       : clk  - system clock, rising edge
//                rst  - synchronous active-high reset
//                bus  - bist_if.slave: start/abort/golden/signature in;
//                       tm/bist_init/busy/done/pass/fail/sig_latched/
//                       pattern_idx out
//  Revision    : 1.0 - initial release
// ============================================================================
module bist_controller
    import bist_pkg::*;
#(
    parameter int PATTERN_COUNT = PATTERN_COUNT_DEF,
    parameter int SIG_W         = SIG_W_DEF,
    parameter int CNT_W         = CNT_W_DEF
) (
    input  wire    clk,
    input  wire    rst,
    bist_if.slave  bus
);

    localparam logic [CNT_W-1:0] c_last_idx = CNT_W'(PATTERN_COUNT - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pass;
    logic             r_fail;
    logic [SIG_W-1:0] r_sig;

    logic             w_tm;
    logic             w_init;
    logic             w_busy;
    logic             w_done;
    logic             w_clear;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and state-decoded outputs. abort is only honoured in the
    // busy states and overrides every busy-state transition.
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        w_tm   = 1'b0;
        w_init = 1'b0;
        w_busy = 1'b0;
        w_done = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.start) w_next = ST_INIT;
            end
            ST_INIT: begin
                w_init = 1'b1;
                w_busy = 1'b1;
                w_next = bus.abort ? ST_IDLE : ST_RUN;
            end
            ST_RUN: begin
                w_tm   = 1'b1;
                w_busy = 1'b1;
                if (bus.abort)                 w_next = ST_IDLE;
                else if (r_cnt == c_last_idx)  w_next = ST_FLUSH;
            end
            ST_FLUSH: begin
                w_tm   = 1'b1;
                w_busy = 1'b1;
                w_next = bus.abort ? ST_IDLE : ST_COMPARE;
            end
            ST_COMPARE: begin
                w_busy = 1'b1;
                w_next = bus.abort ? ST_IDLE : ST_DONE;
            end
            ST_DONE: begin
                w_done = 1'b1;
                if (bus.start) w_next = ST_INIT;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pattern counter: counts only while staying in RUN, so it reads 0 on
    // RUN entry and never carries the terminal value out of RUN.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == ST_RUN && w_next == ST_RUN) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Result registers: stale results are wiped when a new session starts
    // or a running one is aborted; an abort during COMPARE wins over the
    // latch.
    // ------------------------------------------------------------------
    assign w_clear = (w_next == ST_INIT) || (w_busy && bus.abort);

    always_ff @(posedge clk) begin
        if (rst || w_clear) begin
            r_pass <= 1'b0;
            r_fail <= 1'b0;
            r_sig  <= '0;
        end else if (r_state == ST_COMPARE) begin
            r_sig  <= bus.signature;
            r_pass <= (bus.signature == bus.golden);
            r_fail <= (bus.signature != bus.golden);
        end
    end

    assign bus.tm          = w_tm;
    assign bus.bist_init   = w_init;
    assign bus.busy        = w_busy;
    assign bus.done        = w_done;
    assign bus.pass        = r_pass;
    assign bus.fail        = r_fail;
    assign bus.sig_latched = r_sig;
    assign bus.pattern_idx = (r_state == ST_RUN) ? r_cnt : '0;

endmodule : bist_controller
`default_nettype wire
